// File: rtl/mdc_kernel_adapter_ctrl.sv
// mdc_kernel_adapter_ctrl
// Flag and sequencing unit between the HWPE engine FSM and an accelerated
// MDC/HLS kernel. It snoops the sink/source stream handshakes, counts them
// against per-job programmed transfer counts, and produces the engine's
// ready / done / end / idle / busy flags.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   start_i            job start pulse (latches maxes, clears counters)
//   in_valid_i/ready_i snooped sink channel handshake, N_IN wide
//   out_valid_i/ready_i snooped source channel handshake, N_OUT wide
//   in_max_i/out_max_i transfers expected per channel, CNT_W bits each
//   ready_o            all sink channels reached their count (RUN/FIN only)
//   done_o             one-cycle pulse per source handshake seen in RUN
//   end_o              high for the single FIN cycle
//   idle_o / busy_o    state is IDLE / RUN
//   in_cnt_o/out_cnt_o live per-channel counters
//   err_o              sticky surplus-handshake flag
//
// Optional feature: define MDC_KERNEL_ADAPTER_OVF_ERR_EN to build the
// surplus-handshake detector driving err_o; otherwise err_o is tied 0.
module mdc_kernel_adapter_ctrl #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 1,
  parameter int CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [N_IN-1:0]        in_valid_i,
  input  logic [N_IN-1:0]        in_ready_i,
  input  logic [N_OUT-1:0]       out_valid_i,
  input  logic [N_OUT-1:0]       out_ready_i,
  input  logic [N_IN*CNT_W-1:0]  in_max_i,
  input  logic [N_OUT*CNT_W-1:0] out_max_i,
  output logic                   ready_o,
  output logic [N_OUT-1:0]       done_o,
  output logic                   end_o,
  output logic                   idle_o,
  output logic                   busy_o,
  output logic [N_IN*CNT_W-1:0]  in_cnt_o,
  output logic [N_OUT*CNT_W-1:0] out_cnt_o,
  output logic                   err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic [N_IN*CNT_W-1:0]    in_max_r;
  logic [N_IN*CNT_W-1:0]    in_max_nxt_s;
  logic [N_IN*CNT_W-1:0]    in_cnt_r;
  logic [N_IN*CNT_W-1:0]    in_cnt_nxt_s;
  logic [N_OUT*CNT_W-1:0]   out_max_r;
  logic [N_OUT*CNT_W-1:0]   out_max_nxt_s;
  logic [N_OUT*CNT_W-1:0]   out_cnt_r;
  logic [N_OUT*CNT_W-1:0]   out_cnt_nxt_s;
  logic [N_IN-1:0]          in_hs_s;
  logic [N_OUT-1:0]         out_hs_s;
  logic                     in_full_s;
  logic                     out_full_s;

  assign in_cnt_o  = in_cnt_r;
  assign out_cnt_o = out_cnt_r;

  // Handshake detection and next shadow-max / counter values.
  always_comb begin
    in_hs_s       = in_valid_i & in_ready_i;
    out_hs_s      = out_valid_i & out_ready_i;
    in_max_nxt_s  = in_max_r;
    out_max_nxt_s = out_max_r;
    in_cnt_nxt_s  = in_cnt_r;
    out_cnt_nxt_s = out_cnt_r;
    if (start_i) begin
      // start dominates: a coincident handshake is dropped
      in_max_nxt_s  = in_max_i;
      out_max_nxt_s = out_max_i;
      in_cnt_nxt_s  = '0;
      out_cnt_nxt_s = '0;
    end else begin
      case (state_r)
        ST_RUN: begin
          // counting stops at max, so a disabled (max 0) channel never moves
          for (int k = 0; k < N_IN; k++) begin
            if (in_hs_s[k] && (in_cnt_r[k*CNT_W +: CNT_W] < in_max_r[k*CNT_W +: CNT_W])) begin
              in_cnt_nxt_s[k*CNT_W +: CNT_W] = in_cnt_r[k*CNT_W +: CNT_W] + CNT_ONE;
            end else begin
              in_cnt_nxt_s[k*CNT_W +: CNT_W] = in_cnt_r[k*CNT_W +: CNT_W];
            end
          end
          for (int j = 0; j < N_OUT; j++) begin
            if (out_hs_s[j] && (out_cnt_r[j*CNT_W +: CNT_W] < out_max_r[j*CNT_W +: CNT_W])) begin
              out_cnt_nxt_s[j*CNT_W +: CNT_W] = out_cnt_r[j*CNT_W +: CNT_W] + CNT_ONE;
            end else begin
              out_cnt_nxt_s[j*CNT_W +: CNT_W] = out_cnt_r[j*CNT_W +: CNT_W];
            end
          end
        end
        ST_IDLE: in_cnt_nxt_s = in_cnt_r;
        ST_FIN:  in_cnt_nxt_s = in_cnt_r;
        default: in_cnt_nxt_s = in_cnt_r;
      endcase
    end
  end

  // Completion flags evaluated on the post-edge counters so flags land one
  // cycle after the completing handshake.
  always_comb begin
    in_full_s  = 1'b1;
    out_full_s = 1'b1;
    for (int k = 0; k < N_IN; k++) begin
      in_full_s = in_full_s & (in_cnt_nxt_s[k*CNT_W +: CNT_W] == in_max_nxt_s[k*CNT_W +: CNT_W]);
    end
    for (int j = 0; j < N_OUT; j++) begin
      out_full_s = out_full_s & (out_cnt_nxt_s[j*CNT_W +: CNT_W] == out_max_nxt_s[j*CNT_W +: CNT_W]);
    end
  end

  // Job state transitions.
  always_comb begin
    if (start_i) begin
      state_nxt_s = ST_RUN;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_IDLE;
        ST_RUN:  state_nxt_s = out_full_s ? ST_FIN : ST_RUN;
        ST_FIN:  state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // State, shadow maxes, counters and registered flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      in_max_r  <= '0;
      out_max_r <= '0;
      in_cnt_r  <= '0;
      out_cnt_r <= '0;
      ready_o   <= 1'b0;
      done_o    <= '0;
      end_o     <= 1'b0;
      idle_o    <= 1'b1;
      busy_o    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      in_max_r  <= in_max_nxt_s;
      out_max_r <= out_max_nxt_s;
      in_cnt_r  <= in_cnt_nxt_s;
      out_cnt_r <= out_cnt_nxt_s;
      ready_o   <= (state_nxt_s != ST_IDLE) & in_full_s;
      done_o    <= (!start_i && (state_r == ST_RUN)) ? out_hs_s : '0;
      end_o     <= (state_nxt_s == ST_FIN);
      idle_o    <= (state_nxt_s == ST_IDLE);
      busy_o    <= (state_nxt_s == ST_RUN);
    end
  end

`ifdef MDC_KERNEL_ADAPTER_OVF_ERR_EN
  logic ovf_s;
  logic err_r;

  // Surplus handshake: a RUN-state handshake on a channel already at its max.
  always_comb begin
    ovf_s = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      ovf_s = ovf_s | (in_hs_s[k] & (in_cnt_r[k*CNT_W +: CNT_W] >= in_max_r[k*CNT_W +: CNT_W]));
    end
    for (int j = 0; j < N_OUT; j++) begin
      ovf_s = ovf_s | (out_hs_s[j] & (out_cnt_r[j*CNT_W +: CNT_W] >= out_max_r[j*CNT_W +: CNT_W]));
    end
    ovf_s = ovf_s & (state_r == ST_RUN);
  end

  // Sticky error flag, cleared only by reset or a new job.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_r <= 1'b0;
    end else if (start_i) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | ovf_s;
    end
  end

  assign err_o = err_r;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mdc_kernel_adapter_ctrl.sv
module tb_mdc_kernel_adapter_ctrl;

  localparam int N_IN  = 3;
  localparam int N_OUT = 1;
  localparam int CNT_W = 16;
  localparam int VW    = 5 + N_OUT + N_IN*CNT_W + N_OUT*CNT_W;
`ifdef MDC_KERNEL_ADAPTER_OVF_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [N_IN-1:0]        in_valid;
  logic [N_IN-1:0]        in_ready;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;
  logic [N_IN*CNT_W-1:0]  in_max;
  logic [N_OUT*CNT_W-1:0] out_max;
  logic                   ready_o;
  logic [N_OUT-1:0]       done_o;
  logic                   end_o;
  logic                   idle_o;
  logic                   busy_o;
  logic [N_IN*CNT_W-1:0]  in_cnt_o;
  logic [N_OUT*CNT_W-1:0] out_cnt_o;
  logic                   err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mdc_kernel_adapter_ctrl #(.N_IN(N_IN), .N_OUT(N_OUT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .in_valid_i(in_valid), .in_ready_i(in_ready),
    .out_valid_i(out_valid), .out_ready_i(out_ready),
    .in_max_i(in_max), .out_max_i(out_max),
    .ready_o(ready_o), .done_o(done_o), .end_o(end_o), .idle_o(idle_o),
    .busy_o(busy_o), .in_cnt_o(in_cnt_o), .out_cnt_o(out_cnt_o), .err_o(err_o)
  );

  // Reference model: job phase (0 idle, 1 run, 2 fin) plus per-channel tallies.
  int         m_phase;
  int         m_in_max[N_IN];
  int         m_in_cnt[N_IN];
  int         m_out_max[N_OUT];
  int         m_out_cnt[N_OUT];
  bit [N_OUT-1:0] m_done;
  bit         m_err;

  task automatic model_edge();
    bit all_out;
    if (rst) begin
      m_phase = 0; m_done = '0; m_err = 1'b0;
      for (int k = 0; k < N_IN; k++) begin m_in_max[k] = 0; m_in_cnt[k] = 0; end
      for (int j = 0; j < N_OUT; j++) begin m_out_max[j] = 0; m_out_cnt[j] = 0; end
    end else if (start) begin
      m_phase = 1; m_done = '0; m_err = 1'b0;
      for (int k = 0; k < N_IN; k++) begin m_in_max[k] = int'(in_max[k*CNT_W +: CNT_W]); m_in_cnt[k] = 0; end
      for (int j = 0; j < N_OUT; j++) begin m_out_max[j] = int'(out_max[j*CNT_W +: CNT_W]); m_out_cnt[j] = 0; end
    end else begin
      m_done = (m_phase == 1) ? (out_valid & out_ready) : '0;
      if (m_phase == 1) begin
        for (int k = 0; k < N_IN; k++)
          if (in_valid[k] && in_ready[k]) begin
            if (m_in_cnt[k] < m_in_max[k]) m_in_cnt[k]++; else m_err = 1'b1;
          end
        all_out = 1'b1;
        for (int j = 0; j < N_OUT; j++) begin
          if (out_valid[j] && out_ready[j]) begin
            if (m_out_cnt[j] < m_out_max[j]) m_out_cnt[j]++; else m_err = 1'b1;
          end
          if (m_out_cnt[j] != m_out_max[j]) all_out = 1'b0;
        end
        if (all_out) m_phase = 2;
      end else if (m_phase == 2) begin
        m_phase = 0;
      end
    end
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic rdy;
    logic e;
    logic [N_IN*CNT_W-1:0]  ic;
    logic [N_OUT*CNT_W-1:0] oc;
    rdy = (m_phase != 0);
    for (int k = 0; k < N_IN; k++) begin
      if (m_in_cnt[k] != m_in_max[k]) rdy = 1'b0;
      ic[k*CNT_W +: CNT_W] = CNT_W'(m_in_cnt[k]);
    end
    for (int j = 0; j < N_OUT; j++) oc[j*CNT_W +: CNT_W] = CNT_W'(m_out_cnt[j]);
    e = EXP_ERR & m_err;
    return {rdy, m_done, (m_phase == 2), (m_phase == 0), (m_phase == 1), e, ic, oc};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {ready_o, done_o, end_o, idle_o, busy_o, err_o, in_cnt_o, out_cnt_o};
  endfunction

  // Apply the current inputs at the next rising edge, then settle.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_max(input int a, input int b, input int c, input int o);
    in_max  = {CNT_W'(c), CNT_W'(b), CNT_W'(a)};
    out_max = CNT_W'(o);
  endtask

  task automatic no_hs();
    in_valid = '0; in_ready = '0; out_valid = '0; out_ready = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; no_hs(); set_max(0, 0, 0, 0);
    for (int c = 0; c < 2; c++) tick();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = N_IN'($urandom); in_ready = N_IN'($urandom);
      out_valid = N_OUT'($urandom); out_ready = N_OUT'($urandom);
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL reset_idle c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
    total++;
    if ({idle_o, busy_o, ready_o, end_o, done_o, err_o, in_cnt_o, out_cnt_o} !== {1'b1, {(VW-1){1'b0}}}) begin
      bad++; $display("FAIL reset_values got idle=%b busy=%b rdy=%b end=%b cnt=%h exp idle=1 rest 0",
                      idle_o, busy_o, ready_o, end_o, in_cnt_o);
    end
  endtask

  task automatic test_basic();
    int rise_c = -1, idle_c = -1, end_c = -1, dn = 0, en = 0;
    set_max(4, 4, 2, 3); no_hs(); start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (obs_vec() !== exp_vec() || busy_o !== 1'b1 || idle_o !== 1'b0) begin
      bad++; $display("FAIL basic_start got=%h exp=%h", obs_vec(), exp_vec());
    end
    for (int c = 1; c <= 9; c++) begin
      in_valid[0] = (c <= 4); in_valid[1] = (c <= 4); in_valid[2] = (c <= 2);
      in_ready = '1;
      out_valid = N_OUT'((c >= 5) && (c <= 7)); out_ready = '1;
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL basic_cycle c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (ready_o && rise_c < 0) rise_c = c;
      if (done_o[0]) dn++;
      if (end_o) begin en++; end_c = c; end
      if (idle_o && idle_c < 0) idle_c = c;
    end
    total++;
    if (rise_c != 4 || dn != 3 || en != 1 || end_c != 7 || idle_c != 8) begin
      bad++; $display("FAIL basic_timing got rise=%0d done=%0d end=%0d@%0d idle@%0d exp 4 3 1@7 idle@8",
                      rise_c, dn, en, end_c, idle_c);
    end
    no_hs();
  endtask

  task automatic test_disabled();
    int rise_c = -1;
    set_max(0, 5, 0, 1); no_hs(); start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      in_valid[0] = 1'($urandom); in_valid[1] = (c <= 5); in_valid[2] = 1'($urandom);
      in_ready = '1;
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL disabled_cycle c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (ready_o && rise_c < 0) rise_c = c;
    end
    total++;
    if (rise_c != 5) begin
      bad++; $display("FAIL disabled_ready got rise=%0d exp 5", rise_c);
    end
    no_hs(); out_valid = '1; out_ready = '1;
    for (int c = 0; c < 3; c++) begin
      tick();
      out_valid = '0;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL disabled_finish c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
    end
    // all channels disabled: RUN, FIN, IDLE on consecutive cycles
    set_max(0, 0, 0, 0); no_hs(); start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (busy_o !== 1'b1 || idle_o !== 1'b0 || end_o !== 1'b0 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL allzero_run got busy=%b idle=%b end=%b exp 1 0 0", busy_o, idle_o, end_o);
    end
    tick();
    total++;
    if (end_o !== 1'b1 || busy_o !== 1'b0 || ready_o !== 1'b1 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL allzero_fin got end=%b busy=%b ready=%b exp 1 0 1", end_o, busy_o, ready_o);
    end
    tick();
    total++;
    if (idle_o !== 1'b1 || end_o !== 1'b0 || ready_o !== 1'b0 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL allzero_idle got idle=%b end=%b ready=%b exp 1 0 0", idle_o, end_o, ready_o);
    end
  endtask

  task automatic test_restart();
    int en = 0, end_c = -1;
    set_max(2, 2, 2, 3); no_hs(); start = 1'b1;
    tick();
    start = 1'b0; out_valid = '1; out_ready = '1;
    tick();
    tick();
    // restart with handshakes on every channel in the same cycle
    set_max(1, 1, 1, 2); start = 1'b1; in_valid = '1; in_ready = '1;
    tick();
    start = 1'b0;
    total++;
    if (in_cnt_o !== '0 || out_cnt_o !== '0 || end_o !== 1'b0 || done_o !== '0 || busy_o !== 1'b1) begin
      bad++; $display("FAIL restart_clear got in=%h out=%h end=%b done=%b busy=%b exp 0 0 0 0 1",
                      in_cnt_o, out_cnt_o, end_o, done_o, busy_o);
    end
    for (int c = 1; c <= 6; c++) begin
      in_valid = (c == 1) ? '1 : '0;
      out_valid = N_OUT'((c >= 2) && (c <= 3));
      tick();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL restart_cycle c=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (end_o) begin en++; end_c = c; end
    end
    total++;
    if (en != 1 || end_c != 3) begin
      bad++; $display("FAIL restart_end got count=%0d at=%0d exp 1 at 3", en, end_c);
    end
    no_hs();
  endtask

  task automatic test_overflow();
    set_max(2, 0, 0, 1); no_hs(); start = 1'b1;
    tick();
    start = 1'b0; in_valid = 3'b001; in_ready = '1;
    for (int c = 0; c < 3; c++) tick();
    no_hs();
    for (int c = 0; c < 3; c++) begin
      total++;
      if (in_cnt_o[CNT_W-1:0] !== 16'd2 || err_o !== EXP_ERR || obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL overflow_hold c=%0d got cnt=%0d err=%b exp cnt=2 err=%b",
                        c, in_cnt_o[CNT_W-1:0], err_o, EXP_ERR);
      end
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (err_o !== 1'b0 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL overflow_clear got err=%b exp 0", err_o);
    end
  endtask

  task automatic test_reset_midrun();
    set_max(3, 3, 3, 2); no_hs(); start = 1'b1;
    tick();
    start = 1'b0; in_valid = '1; in_ready = '1; out_valid = '1; out_ready = '1;
    tick();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    total++;
    if (idle_o !== 1'b1 || busy_o !== 1'b0 || in_cnt_o !== '0 || out_cnt_o !== '0 || obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL midrun_reset got idle=%b busy=%b in=%h out=%h exp 1 0 0 0",
                      idle_o, busy_o, in_cnt_o, out_cnt_o);
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = '1; in_ready = '1; out_valid = '1; out_ready = '1;
      tick();
      total++;
      if (in_cnt_o !== '0 || out_cnt_o !== '0 || done_o !== '0 || obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL idle_hs c=%0d got in=%h out=%h done=%b exp 0 0 0", c, in_cnt_o, out_cnt_o, done_o);
      end
    end
    no_hs();
  endtask

  task automatic test_random();
    for (int job = 0; job < 8; job++) begin
      set_max($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
      no_hs(); start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 30; c++) begin
        in_valid = N_IN'($urandom); in_ready = N_IN'($urandom);
        out_valid = N_OUT'($urandom); out_ready = N_OUT'($urandom);
        start = ($urandom_range(0, 31) == 0);
        tick();
        start = 1'b0;
        total++;
        if (obs_vec() !== exp_vec()) begin
          bad++; $display("FAIL random job=%0d c=%0d got=%h exp=%h", job, c, obs_vec(), exp_vec());
        end
      end
    end
    no_hs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_disabled();
    test_restart();
    test_overflow();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdc_kernel_adapter_ctrl.md
# mdc_kernel_adapter_ctrl

Parametrised flag and sequencing unit that sits between the HWPE engine FSM and an accelerated MDC/HLS kernel. It snoops the stream handshakes on N_IN sink and N_OUT source channels. Per-start programmable transfer counts replace the fixed "one input = ready" rule. From these it generates the engine's ready, per-output done, end-of-job and idle flags.

## Interface
- N_IN, 3, number of sink (input) stream channels, 1..8
- N_OUT, 1, number of source (output) stream channels, 1..8
- CNT_W, 16, width of every transfer counter and max field
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  job start pulse from engine FSM
- in_valid_i  in  N_IN  sink channel valid, snooped
- in_ready_i  in  N_IN  sink channel ready, snooped
- out_valid_i  in  N_OUT  source channel valid, snooped
- out_ready_i  in  N_OUT  source channel ready, snooped
- in_max_i  in  N_IN*CNT_W  transfers expected per sink channel; channel k at [k*CNT_W +: CNT_W]
- out_max_i  in  N_OUT*CNT_W  transfers expected per source channel
- ready_o  out  1  all sink channels have received their programmed count
- done_o  out  N_OUT  one-cycle pulse per source handshake
- end_o  out  1  one-cycle pulse when all source channels are complete
- idle_o  out  1  no job in progress
- busy_o  out  1  state is RUN
- in_cnt_o  out  N_IN*CNT_W  live sink counters
- out_cnt_o  out  N_OUT*CNT_W  live source counters
- err_o  out  1  sticky overflow flag; present only with the macro, otherwise tied 0

## Operation
- Handshake on channel k: valid&ready high in the same cycle.
- start_i latches in_max_i and out_max_i into shadow registers. It clears all counters, done_o and err_o, and moves to RUN.
- A max of 0 disables the channel: it is complete immediately and its handshakes are ignored.
- In RUN, each sink counter increments on a handshake while it is below its max, then saturates at the max. Source counters behave the same way.
- State machine:
  - IDLE → RUN on start_i.
  - RUN → FIN when every source counter equals its max (including all-zero maxes).
  - FIN → IDLE unconditionally after 1 cycle.
  - start_i in any state → RUN with a full re-init. start_i dominates any handshake in the same cycle; that handshake is not counted.
- Handshakes seen in IDLE or FIN are not counted.
- ready_o = every sink counter equals its shadow max. It is valid in RUN and FIN, and forced 0 in IDLE.
- done_o[j]: registered copy of the source j handshake, counted or not, in RUN only.
- end_o: high exactly in FIN.
- idle_o: high in IDLE. busy_o: high in RUN.
- Counter arithmetic is unsigned CNT_W-bit. Counters never wrap.

## Timing
- All outputs are registered.
- Reset values: state IDLE, idle_o=1, all other outputs 0, all counters and shadow maxes 0.
- Start to RUN: start_i in cycle t gives busy_o=1 and idle_o=0 at t+1.
- Input completion: final sink handshake at t gives ready_o=1 at t+1. ready_o holds until the next start_i or IDLE.
- Output handshake at t gives done_o[j]=1 for cycle t+1 only. Back-to-back handshakes give a continuous pulse train.
- End of job: final source handshake at t gives end_o=1 at t+1 (FIN), then idle_o=1 and end_o=0 at t+2.
- All maxes 0: start_i at t gives RUN at t+1, FIN at t+2, IDLE at t+3.
- rst_i mid-job: returns to the reset values on the next edge, regardless of start_i.

## Configuration
- MDC_KERNEL_ADAPTER_OVF_ERR_EN defined:
  - A handshake on a channel already at its max (or disabled), while in RUN, sets err_o at the next edge.
  - err_o holds until start_i or rst_i.
  - Counters still saturate.
- Not defined:
  - The overflow comparison logic is not built.
  - err_o is constant 0.
  - Surplus handshakes are silently ignored.

## Test plan
- Reset, then idle 10 cycles → idle_o=1, all other outputs 0, counters 0.
- Basic job:
  - Stimulus: N_IN=3, in_max={4,4,2}, out_max=3, start_i, channels streamed at full rate.
  - Required: ready_o rises 1 cycle after the 4th a/b and 2nd c handshake, done_o pulses 3 times, end_o exactly 1 cycle, idle_o 1 cycle later.
- Disabled channels:
  - in_max={0,5,0}: ready_o depends only on channel 1.
  - All maxes 0: RUN→FIN→IDLE in 3 cycles with no handshakes.
- Restart: start_i again after 2 of 3 outputs → counters 0, end_o not asserted, a new job with new maxes completes correctly. A handshake coincident with start_i is not counted.
- Overflow (macro defined): in_max[0]=2, 3 handshakes → in_cnt stays 2, err_o=1 until next start_i. With the macro undefined, the same stimulus gives err_o=0.
- rst_i asserted mid-RUN together with start_i → next cycle idle_o=1, busy_o=0, counters 0. Handshakes seen in IDLE leave counters at 0.
